// File: rtl/detector_sequencer_if.sv
// Host-side bundle for detector_sequencer: run request, pattern, status and Z counts.
// DET_CHECK_EN adds the expected-count inputs and the match result.
interface detector_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] z1_count;
    logic [CNT_W-1:0] z2_count;
`ifdef DET_CHECK_EN
    logic [CNT_W-1:0] exp_z1;
    logic [CNT_W-1:0] exp_z2;
    logic             match;

    modport master (
        output start, pattern, exp_z1, exp_z2,
        input  busy, done, z1_count, z2_count, match
    );
    modport slave (
        input  start, pattern, exp_z1, exp_z2,
        output busy, done, z1_count, z2_count, match
    );
`else
    modport master (
        output start, pattern,
        input  busy, done, z1_count, z2_count
    );
    modport slave (
        input  start, pattern,
        output busy, done, z1_count, z2_count
    );
`endif
endinterface

// File: rtl/detector_sequencer.sv
// Sequences one X-run detector: clears it, shifts a WIDTH-bit pattern LSB first, counts Z1/Z2.
// Latency: done pulses WIDTH+2 cycles after start is accepted; optional DET_CHECK_EN adds match.
// Backpressure: none; start is accepted only in IDLE, requests while busy are dropped.
module detector_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    detector_sequencer_if.slave   host,
    input  logic                  det_Z1,
    input  logic                  det_Z2,
    output logic                  det_reset,
    output logic                  X
);
    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] z1_q, z1_d;
    logic [CNT_W-1:0] z2_q, z2_d;
`ifdef DET_CHECK_EN
    logic [CNT_W-1:0] exp_z1_q, exp_z1_d;
    logic [CNT_W-1:0] exp_z2_q, exp_z2_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            z1_q     <= '0;
            z2_q     <= '0;
`ifdef DET_CHECK_EN
            exp_z1_q <= '0;
            exp_z2_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            z1_q     <= z1_d;
            z2_q     <= z2_d;
`ifdef DET_CHECK_EN
            exp_z1_q <= exp_z1_d;
            exp_z2_q <= exp_z2_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        z1_d     = z1_q;
        z2_d     = z2_q;
`ifdef DET_CHECK_EN
        exp_z1_d = exp_z1_q;
        exp_z2_d = exp_z2_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    state_d  = S_CLR;
                    shreg_d  = host.pattern;
                    bitcnt_d = '0;
                    z1_d     = '0;
                    z2_d     = '0;
`ifdef DET_CHECK_EN
                    exp_z1_d = host.exp_z1;
                    exp_z2_d = host.exp_z2;
`endif
                end
            end
            S_CLR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d  = shreg_q >> 1;
                bitcnt_d = bitcnt_q + 1'b1;
                // Detector outputs are Mealy on the X we drive this cycle, so count them now.
                if (det_Z1 && (z1_q != CNT_MAX)) z1_d = z1_q + 1'b1;
                if (det_Z2 && (z2_q != CNT_MAX)) z2_d = z2_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    state_d  = S_DONE;
                    bitcnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign det_reset     = reset | (state_q == S_CLR);
    assign X             = (state_q == S_SHIFT) & shreg_q[0];
    assign host.busy     = (state_q != S_IDLE);
    assign host.done     = (state_q == S_DONE);
    assign host.z1_count = z1_q;
    assign host.z2_count = z2_q;
`ifdef DET_CHECK_EN
    assign host.match    = (state_q == S_DONE) && (z1_q == exp_z1_q) && (z2_q == exp_z2_q);
`endif
endmodule

// File: tb/tb_detector_sequencer.sv
// Bench for detector_sequencer: two instances (CNT_W=4 and CNT_W=2) share stimulus,
// each driving its own behavioural X-run detector.
module tb_detector_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    detector_sequencer_if #(.WIDTH(8), .CNT_W(4)) hif ();
    detector_sequencer_if #(.WIDTH(8), .CNT_W(2)) hif2 ();

    assign hif.start    = start;
    assign hif.pattern  = pattern;
    assign hif2.start   = start;
    assign hif2.pattern = pattern;

`ifdef DET_CHECK_EN
    logic [3:0] exp1, exp2;
    logic [3:0] exp1_v, exp2_v;
    logic [1:0] exp1_n, exp2_n;
    always_comb begin
        exp1_v = exp1;
        exp2_v = exp2;
        exp1_n = exp1_v[1:0];
        exp2_n = exp2_v[1:0];
    end
    assign hif.exp_z1  = exp1;
    assign hif.exp_z2  = exp2;
    assign hif2.exp_z1 = exp1_n;
    assign hif2.exp_z2 = exp2_n;
`endif

    logic dz1_a, dz2_a, drst_a, x_a;
    logic dz1_b, dz2_b, drst_b, x_b;

    detector_sequencer #(.WIDTH(8), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst), .host(hif),
        .det_Z1(dz1_a), .det_Z2(dz2_a), .det_reset(drst_a), .X(x_a)
    );
    detector_sequencer #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst), .host(hif2),
        .det_Z1(dz1_b), .det_Z2(dz2_b), .det_reset(drst_b), .X(x_b)
    );

    // Detector: s0 -1-> s1 -1-> s2, s2 stays on 1, any 0 returns to s0.
    logic [1:0] dst_a, dst_b;
    always_ff @(posedge clk) begin
        if (drst_a) dst_a <= 2'd0;
        else if (x_a) dst_a <= (dst_a == 2'd0) ? 2'd1 : 2'd2;
        else dst_a <= 2'd0;
        if (drst_b) dst_b <= 2'd0;
        else if (x_b) dst_b <= (dst_b == 2'd0) ? 2'd1 : 2'd2;
        else dst_b <= 2'd0;
    end
    assign dz1_a = (dst_a == 2'd2) && !x_a;
    assign dz2_a = (dst_a == 2'd2) &&  x_a;
    assign dz1_b = (dst_b == 2'd2) && !x_b;
    assign dz2_b = (dst_b == 2'd2) &&  x_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start, then watches a fixed 24-cycle window (cycle k = after edge k).
    task automatic do_run(input logic [7:0] pat, input int restart_at, input int reset_at,
                          output int cyc, output int ndone, output logic [7:0] xbits,
                          output logic drst_clr, output logic drst_rst, output logic busy_after);
        cyc = -1; ndone = 0; xbits = '0; drst_clr = 1'b0; drst_rst = 1'b0; busy_after = 1'b1;
        pattern = pat;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            start = (k == restart_at);
            rst   = (k == reset_at);
            #1;
            if (hif.done) begin
                ndone++;
                if (cyc < 0) cyc = k;
            end
            if (k == 1) drst_clr = drst_a;
            if (k >= 2 && k <= 9) xbits[k-2] = x_a;
            if (k == reset_at) drst_rst = drst_a;
            if (k == reset_at + 1) busy_after = hif.busy;
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pattern = 8'hFF;
        tick();
        tick();
        n_vec++; if (drst_a !== 1'b1) begin n_err++; $display("FAIL reset_det_reset got=%b exp=1", drst_a); end
        tick();
        rst = 1'b0; start = 1'b0;
        #1;
        n_vec++; if (hif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", hif.busy); end
        n_vec++; if (hif.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", hif.done); end
        n_vec++; if (x_a !== 1'b0) begin n_err++; $display("FAIL reset_x got=%b exp=0", x_a); end
        n_vec++; if (drst_a !== 1'b0) begin n_err++; $display("FAIL reset_det_reset_rel got=%b exp=0", drst_a); end
        n_vec++; if (hif.z1_count !== 4'd0) begin n_err++; $display("FAIL reset_z1 got=%0d exp=0", hif.z1_count); end
        n_vec++; if (hif.z2_count !== 4'd0) begin n_err++; $display("FAIL reset_z2 got=%0d exp=0", hif.z2_count); end
        tick();
    endtask

    task automatic test_pattern_07();
        int cyc, nd; logic [7:0] xb; logic dc, dr, ba;
        do_run(8'h07, 0, 0, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL p07_latency got=%0d exp=10", cyc); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL p07_done_pulses got=%0d exp=1", nd); end
        n_vec++; if (dc !== 1'b1) begin n_err++; $display("FAIL p07_clr_det_reset got=%b exp=1", dc); end
        n_vec++; if (xb !== 8'h07) begin n_err++; $display("FAIL p07_x_stream got=%h exp=07", xb); end
        n_vec++; if (hif.z1_count !== 4'd1) begin n_err++; $display("FAIL p07_z1 got=%0d exp=1", hif.z1_count); end
        n_vec++; if (hif.z2_count !== 4'd1) begin n_err++; $display("FAIL p07_z2 got=%0d exp=1", hif.z2_count); end
        n_vec++; if (hif.busy !== 1'b0) begin n_err++; $display("FAIL p07_idle_busy got=%b exp=0", hif.busy); end
    endtask

    task automatic test_all_ones();
        int cyc, nd; logic [7:0] xb; logic dc, dr, ba;
        do_run(8'hFF, 0, 0, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL pff_latency got=%0d exp=10", cyc); end
        n_vec++; if (hif.z1_count !== 4'd0) begin n_err++; $display("FAIL pff_z1 got=%0d exp=0", hif.z1_count); end
        n_vec++; if (hif.z2_count !== 4'd6) begin n_err++; $display("FAIL pff_z2 got=%0d exp=6", hif.z2_count); end
        n_vec++; if (hif2.z2_count !== 2'd3) begin n_err++; $display("FAIL pff_sat_z2 got=%0d exp=3", hif2.z2_count); end
        n_vec++; if (hif2.z1_count !== 2'd0) begin n_err++; $display("FAIL pff_sat_z1 got=%0d exp=0", hif2.z1_count); end
        tick(); tick(); tick();
        n_vec++; if (hif.z2_count !== 4'd6) begin n_err++; $display("FAIL pff_hold_z2 got=%0d exp=6", hif.z2_count); end
    endtask

    task automatic test_mixed();
        int cyc, nd; logic [7:0] xb; logic dc, dr, ba;
        do_run(8'h6D, 0, 0, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (hif.z1_count !== 4'd2) begin n_err++; $display("FAIL p6d_z1 got=%0d exp=2", hif.z1_count); end
        n_vec++; if (hif.z2_count !== 4'd0) begin n_err++; $display("FAIL p6d_z2 got=%0d exp=0", hif.z2_count); end
        n_vec++; if (xb !== 8'h6D) begin n_err++; $display("FAIL p6d_x_stream got=%h exp=6d", xb); end
        do_run(8'h00, 0, 0, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL p00_done_pulses got=%0d exp=1", nd); end
        n_vec++; if (hif.z1_count !== 4'd0) begin n_err++; $display("FAIL p00_z1 got=%0d exp=0", hif.z1_count); end
        n_vec++; if (hif.z2_count !== 4'd0) begin n_err++; $display("FAIL p00_z2 got=%0d exp=0", hif.z2_count); end
    endtask

    task automatic test_start_while_busy();
        int cyc, nd; logic [7:0] xb; logic dc, dr, ba;
        do_run(8'h07, 4, 0, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL restart_done_pulses got=%0d exp=1", nd); end
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL restart_latency got=%0d exp=10", cyc); end
        n_vec++; if (hif.z1_count !== 4'd1) begin n_err++; $display("FAIL restart_z1 got=%0d exp=1", hif.z1_count); end
        n_vec++; if (hif.z2_count !== 4'd1) begin n_err++; $display("FAIL restart_z2 got=%0d exp=1", hif.z2_count); end
    endtask

    task automatic test_reset_mid_run();
        int cyc, nd; logic [7:0] xb; logic dc, dr, ba;
        do_run(8'h07, 0, 5, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL abort_done_pulses got=%0d exp=0", nd); end
        n_vec++; if (dr !== 1'b1) begin n_err++; $display("FAIL abort_det_reset got=%b exp=1", dr); end
        n_vec++; if (ba !== 1'b0) begin n_err++; $display("FAIL abort_busy_next got=%b exp=0", ba); end
        n_vec++; if (hif.z2_count !== 4'd0) begin n_err++; $display("FAIL abort_z2 got=%0d exp=0", hif.z2_count); end
        n_vec++; if (hif.z1_count !== 4'd0) begin n_err++; $display("FAIL abort_z1 got=%0d exp=0", hif.z1_count); end
        do_run(8'h6D, 0, 0, cyc, nd, xb, dc, dr, ba);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL rerun_latency got=%0d exp=10", cyc); end
        n_vec++; if (hif.z1_count !== 4'd2) begin n_err++; $display("FAIL rerun_z1 got=%0d exp=2", hif.z1_count); end
    endtask

`ifdef DET_CHECK_EN
    task automatic test_check();
        logic m_done, m_idle;
        for (int r = 0; r < 2; r++) begin
            exp1 = 4'd1;
            exp2 = (r == 0) ? 4'd1 : 4'd2;
            pattern = 8'h07;
            start = 1'b1;
            tick();
            start = 1'b0;
            m_done = 1'b0;
            m_idle = 1'b0;
            for (int k = 1; k <= 24; k++) begin
                if (hif.done) m_done = hif.match;
                else if (hif.match) m_idle = 1'b1;
                tick();
            end
            n_vec++; if (m_done !== (r == 0)) begin n_err++; $display("FAIL check_match_r%0d got=%b exp=%b", r, m_done, (r == 0)); end
            n_vec++; if (m_idle !== 1'b0) begin n_err++; $display("FAIL check_match_outside_done_r%0d got=%b exp=0", r, m_idle); end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; pattern = 8'h00;
`ifdef DET_CHECK_EN
        exp1 = 4'd0; exp2 = 4'd0;
`endif
        test_reset();
        test_pattern_07();
        test_all_ones();
        test_mixed();
        test_start_while_busy();
        test_reset_mid_run();
`ifdef DET_CHECK_EN
        test_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
